// File: rtl/dac_waveform_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_waveform_sequencer_if
// Brief    : Host, timing and DAC-side signal bundle for dac_waveform_sequencer.
// Revision : 1.0
// ============================================================================
interface dac_waveform_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       main_state;
    logic [5:0]        channel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [15:0]       num_loops;
    logic              arm;
    logic              disarm;
    logic              trigger;
    logic [15:0]       DAC_sequencer_out;
    logic              use_sequencer;
    logic              seq_busy;
    logic              seq_done;
    logic              config_error;

    modport master (
        output main_state, channel, wr_en, wr_addr, wr_data,
               start_addr, end_addr, num_loops, arm, disarm, trigger,
        input  DAC_sequencer_out, use_sequencer, seq_busy, seq_done, config_error
    );

    modport slave (
        input  main_state, channel, wr_en, wr_addr, wr_data,
               start_addr, end_addr, num_loops, arm, disarm, trigger,
        output DAC_sequencer_out, use_sequencer, seq_busy, seq_done, config_error
    );
endinterface
`default_nettype wire

// File: rtl/dac_waveform_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_waveform_sequencer
// Brief    : Per-DAC sample-table playback (arm/trigger, looped region, midscale
//            return). Optional macro DAC_SEQ_RETRIGGER_EN enables restart on a
//            trigger edge during RUN/DONE.
// Revision : 1.0
// ============================================================================
module dac_waveform_sequencer #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] ms_clk1_a    = 32'd100,
    parameter logic [5:0]  STEP_CHANNEL = 6'd0
) (
    input  logic                     dataclk,
    input  logic                     reset,
    dac_waveform_sequencer_if.slave  bus
);
    localparam logic [15:0] c_MIDSCALE = 16'h8000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_end, w_end_nxt;
    logic [15:0]       r_num_loops, w_num_loops_nxt;
    logic [15:0]       r_loops_left, w_loops_nxt;
    logic [15:0]       r_out, w_out_nxt;
    logic              r_done, w_done_nxt;
    logic              r_cfg_err, w_cfg_err_nxt;
    logic              r_trig_prev;
    logic [15:0]       r_rd_data;
    logic [15:0]       r_mem [0:(1<<ADDR_W)-1];

    logic w_tick, w_trig_edge, w_at_end, w_rewind;

    assign w_tick      = (bus.main_state == ms_clk1_a) && (bus.channel == STEP_CHANNEL);
    assign w_trig_edge = bus.trigger & ~r_trig_prev;
    assign w_at_end    = (r_ptr == r_end);
    assign w_rewind    = (r_num_loops == 16'd0) || (r_loops_left > 16'd1);

    // Read-first table: rd_data always reflects mem[ptr] from the previous cycle.
    always_ff @(posedge dataclk) begin
        if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        r_rd_data <= r_mem[r_ptr];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_end_nxt       = r_end;
        w_num_loops_nxt = r_num_loops;
        w_loops_nxt     = r_loops_left;
        w_out_nxt       = r_out;
        w_done_nxt      = 1'b0;
        w_cfg_err_nxt   = r_cfg_err;

        if (bus.disarm) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = c_MIDSCALE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_out_nxt = c_MIDSCALE;
                    if (bus.arm) begin
                        if (bus.end_addr >= bus.start_addr) begin
                            w_state_nxt     = S_ARMED;
                            w_ptr_nxt       = bus.start_addr;
                            w_end_nxt       = bus.end_addr;
                            w_num_loops_nxt = bus.num_loops;
                            w_loops_nxt     = bus.num_loops;
                            w_cfg_err_nxt   = 1'b0;
                        end else begin
                            w_cfg_err_nxt   = 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (w_trig_edge) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
`ifdef DAC_SEQ_RETRIGGER_EN
                    if (w_trig_edge) begin
                        w_state_nxt     = S_RUN;
                        w_ptr_nxt       = bus.start_addr;
                        w_end_nxt       = bus.end_addr;
                        w_num_loops_nxt = bus.num_loops;
                        w_loops_nxt     = bus.num_loops;
                    end else
`endif
                    if (w_tick) begin
                        w_out_nxt = r_rd_data;
                        if (!w_at_end) begin
                            w_ptr_nxt = r_ptr + 1'b1;
                        end else if (w_rewind) begin
                            // Region bounds and loop count are re-sampled at every wrap.
                            w_ptr_nxt       = bus.start_addr;
                            w_end_nxt       = bus.end_addr;
                            w_num_loops_nxt = bus.num_loops;
                            if (r_num_loops != 16'd0) begin
                                w_loops_nxt = r_loops_left - 16'd1;
                            end
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef DAC_SEQ_RETRIGGER_EN
                    if (w_trig_edge) begin
                        w_state_nxt     = S_RUN;
                        w_ptr_nxt       = bus.start_addr;
                        w_end_nxt       = bus.end_addr;
                        w_num_loops_nxt = bus.num_loops;
                        w_loops_nxt     = bus.num_loops;
                    end else
`endif
                    if (w_tick) begin
                        w_state_nxt = S_IDLE;
                        w_out_nxt   = c_MIDSCALE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = c_MIDSCALE;
                end
            endcase
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_end        <= '0;
            r_num_loops  <= 16'd0;
            r_loops_left <= 16'd0;
            r_out        <= c_MIDSCALE;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_trig_prev  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_end        <= w_end_nxt;
            r_num_loops  <= w_num_loops_nxt;
            r_loops_left <= w_loops_nxt;
            r_out        <= w_out_nxt;
            r_done       <= w_done_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
            r_trig_prev  <= bus.trigger;
        end
    end

    assign bus.DAC_sequencer_out = r_out;
    assign bus.use_sequencer     = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.seq_busy          = (r_state != S_IDLE);
    assign bus.seq_done          = r_done;
    assign bus.config_error      = r_cfg_err;
endmodule
`default_nettype wire
